// File: rtl/motor_pkg.sv
// Shared types and defaults for the motor duty-cycle sequencer.
package motor_pkg;

  localparam int DUTY_W          = 8;
  localparam int CRUISE_DUTY_DEF = 150;
  localparam int TURN_DUTY_DEF   = 180;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RAMP = 3'd1,
    ST_RUN  = 3'd2,
    ST_STOP = 3'd3,
    ST_HOLD = 3'd4
  } state_e;

  // The motor is considered "driven" while ramping or running.
  function automatic logic is_drive(state_e s);
    return (s == ST_RAMP) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..TICK_DIV-1 counter; tick is high in the cycle before the wrap,
// so the consumer acts on the wrapping edge. clr restarts the count.
module tick_prescaler #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/motor_duty_sched.sv
// Duty-cycle sequencer for the PWM motor generator: soft ramping between
// cruise/turn targets, obstacle stop with restart hold-off, and enable gating.
module motor_duty_sched #(
  parameter int DUTY_W      = motor_pkg::DUTY_W,
  parameter int CRUISE_DUTY = motor_pkg::CRUISE_DUTY_DEF,
  parameter int TURN_DUTY   = motor_pkg::TURN_DUTY_DEF,
  parameter int RAMP_STEP   = 10,
  parameter int TICK_DIV    = 50000,
  parameter int HOLD_TICKS  = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              ir,
  input  logic              tin,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_upd,
  output logic              led1,
  output logic              led2,
  output logic [2:0]        state_o
);

  import motor_pkg::*;

  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [DUTY_W-1:0] CRUISE_V = DUTY_W'(CRUISE_DUTY);
  localparam logic [DUTY_W-1:0] TURN_V   = DUTY_W'(TURN_DUTY);
  localparam logic [DUTY_W:0]   STEP_V   = (DUTY_W + 1)'(RAMP_STEP);
  localparam logic [HW-1:0]     HOLD_V   = HW'(HOLD_TICKS);

  logic ir_meta_q, irs_q, tin_meta_q, tins_q;
  state_e state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d, target, ramp_val;
  logic [DUTY_W:0] up_sum, dn_diff, tgt_ext;
  logic [HW-1:0] hold_q, hold_d;
  logic duty_upd_q, led1_q, led2_q;
  logic tick, clr;

  assign target = tins_q ? TURN_V : CRUISE_V;

  // One ramp step toward target, widened by a bit so neither direction can wrap.
  always_comb begin
    tgt_ext  = {1'b0, target};
    up_sum   = {1'b0, duty_q} + STEP_V;
    dn_diff  = {1'b0, duty_q} - STEP_V;
    ramp_val = target;
    if (duty_q < target) begin
      if (up_sum < tgt_ext) ramp_val = up_sum[DUTY_W-1:0];
    end else if (duty_q > target) begin
      if (!dn_diff[DUTY_W] && (dn_diff > tgt_ext)) ramp_val = dn_diff[DUTY_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    hold_d  = hold_q;
    if (!en) begin
      state_d = ST_IDLE;
      duty_d  = '0;
    end else if (irs_q && (state_q inside {ST_RAMP, ST_RUN, ST_HOLD})) begin
      state_d = ST_STOP;
      duty_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          duty_d = '0;
          if (!irs_q) state_d = ST_RAMP;
        end
        ST_RAMP: begin
          if (duty_q == target) state_d = ST_RUN;
          else if (tick)        duty_d  = ramp_val;
        end
        ST_RUN: begin
          if (duty_q != target) state_d = ST_RAMP;
        end
        ST_STOP: begin
          duty_d = '0;
          hold_d = '0;
          if (!irs_q) state_d = ST_HOLD;
        end
        ST_HOLD: begin
          duty_d = '0;
          if (hold_q == HOLD_V) state_d = ST_RAMP;
          else if (tick)        hold_d  = hold_q + 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
          duty_d  = '0;
        end
      endcase
    end
  end

  // Any state change restarts the tick period, swallowing a coincident tick.
  assign clr = (state_d != state_q);

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_meta_q  <= 1'b0;
      irs_q      <= 1'b0;
      tin_meta_q <= 1'b0;
      tins_q     <= 1'b0;
      state_q    <= ST_IDLE;
      duty_q     <= '0;
      hold_q     <= '0;
      duty_upd_q <= 1'b0;
      led1_q     <= 1'b0;
      led2_q     <= 1'b0;
    end else begin
      ir_meta_q  <= ir;
      irs_q      <= ir_meta_q;
      tin_meta_q <= tin;
      tins_q     <= tin_meta_q;
      state_q    <= state_d;
      duty_q     <= duty_d;
      hold_q     <= hold_d;
      duty_upd_q <= (duty_d != duty_q);
      // LEDs registered from next-state values so they line up with state_q/tins_q.
      led1_q     <= is_drive(state_d);
      led2_q     <= is_drive(state_d) & tin_meta_q;
    end
  end

  assign duty     = duty_q;
  assign duty_upd = duty_upd_q;
  assign led1     = led1_q;
  assign led2     = led2_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_motor_duty_sched.sv
// Table-driven bench for motor_duty_sched with a duty_upd scoreboard.
module tb_motor_duty_sched;

  logic       clk, rst_n, en, ir, tin;
  logic [7:0] duty;
  logic       duty_upd, led1, led2;
  logic [2:0] state_o;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic       en, ir, tin;
    int         n;
    logic       push;
    logic [7:0] pv;
    int         duty, st, l1, l2;
  } vec_t;
  vec_t vecs[$];

  motor_duty_sched #(
    .TICK_DIV  (4),
    .RAMP_STEP (50),
    .HOLD_TICKS(2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .ir      (ir),
    .tin     (tin),
    .duty    (duty),
    .duty_upd(duty_upd),
    .led1    (led1),
    .led2    (led2),
    .state_o (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic e, input logic i, input logic t, input int n,
                     input logic p, input int pv, input int d, input int s,
                     input int l1, input int l2);
    vec_t v;
    v.en = e; v.ir = i; v.tin = t; v.n = n; v.push = p; v.pv = 8'(pv);
    v.duty = d; v.st = s; v.l1 = l1; v.l2 = l2;
    vecs.push_back(v);
  endtask

  // Every duty_upd pulse must match the next expected duty value.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (duty_upd === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL upd_unexpected: got duty_upd=1 duty=%0d, expected no pulse", duty);
        end else begin
          e = sb.pop_front();
          if (duty !== e) begin
            bad++;
            $display("FAIL upd_value: got duty=%0d, expected %0d", duty, e);
          end
        end
      end
    end
  end

  initial begin
    // states: 0 IDLE, 1 RAMP, 2 RUN, 3 STOP, 4 HOLD
    // soft start
    add(1,0,0,1, 0,0,   0,1,1,0);
    add(1,0,0,3, 0,0,   0,1,1,0);
    add(1,0,0,1, 1,50,  50,1,1,0);
    add(1,0,0,4, 1,100, 100,1,1,0);
    add(1,0,0,4, 1,150, 150,1,1,0);
    add(1,0,0,1, 0,0,   150,2,1,0);
    add(1,0,0,5, 0,0,   150,2,1,0);
    // turn ramp up (clamped at 180) and back down
    add(1,0,1,2, 0,0,   150,2,1,1);
    add(1,0,1,1, 0,0,   150,1,1,1);
    add(1,0,1,3, 0,0,   150,1,1,1);
    add(1,0,1,1, 1,180, 180,1,1,1);
    add(1,0,1,1, 0,0,   180,2,1,1);
    add(1,0,0,3, 0,0,   180,1,1,0);
    add(1,0,0,4, 1,150, 150,1,1,0);
    add(1,0,0,1, 0,0,   150,2,1,0);
    // restart via IDLE, obstacle at duty=100, hold-off, restart
    add(0,0,0,1, 1,0,   0,0,0,0);
    add(1,0,0,1, 0,0,   0,1,1,0);
    add(1,0,0,4, 1,50,  50,1,1,0);
    add(1,0,0,4, 1,100, 100,1,1,0);
    add(1,1,0,2, 0,0,   100,1,1,0);
    add(1,1,0,1, 1,0,   0,3,0,0);
    add(1,1,0,3, 0,0,   0,3,0,0);
    add(1,0,0,2, 0,0,   0,3,0,0);
    add(1,0,0,1, 0,0,   0,4,0,0);
    add(1,0,0,8, 0,0,   0,4,0,0);
    add(1,0,0,1, 0,0,   0,1,1,0);
    add(1,0,0,4, 1,50,  50,1,1,0);
    // glitch in HOLD: hold count must restart
    add(1,1,0,3, 1,0,   0,3,0,0);
    add(1,0,0,3, 0,0,   0,4,0,0);
    add(1,0,0,4, 0,0,   0,4,0,0);
    add(1,1,0,3, 0,0,   0,3,0,0);
    add(1,0,0,3, 0,0,   0,4,0,0);
    add(1,0,0,5, 0,0,   0,4,0,0);
    add(1,0,0,3, 0,0,   0,4,0,0);
    add(1,0,0,1, 0,0,   0,1,1,0);
    add(1,0,0,4, 1,50,  50,1,1,0);
    add(1,0,0,4, 1,100, 100,1,1,0);
    add(1,0,0,4, 1,150, 150,1,1,0);
    add(1,0,0,1, 0,0,   150,2,1,0);
    // en fall coincides with irs rise in RUN: IDLE wins
    add(1,1,0,2, 0,0,   150,2,1,0);
    add(0,1,0,1, 1,0,   0,0,0,0);
    add(0,1,0,3, 0,0,   0,0,0,0);
    // IDLE ignores sensor and turn inputs
    add(0,0,1,3, 0,0,   0,0,0,0);
    add(0,1,0,3, 0,0,   0,0,0,0);
    add(0,0,1,3, 0,0,   0,0,0,0);
    add(0,1,1,3, 0,0,   0,0,0,0);
    add(0,0,0,3, 0,0,   0,0,0,0);

    rst_n = 1'b0; en = 1'b1; ir = 1'b0; tin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_duty", int'(duty), 0);
    chk("rst_upd", int'(duty_upd), 0);
    chk("rst_led1", int'(led1), 0);
    chk("rst_led2", int'(led2), 0);
    chk("rst_state", int'(state_o), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      en = vecs[i].en; ir = vecs[i].ir; tin = vecs[i].tin;
      if (vecs[i].push) sb.push_back(vecs[i].pv);
      repeat (vecs[i].n) @(negedge clk);
      chk($sformatf("row%0d_duty", i), int'(duty), vecs[i].duty);
      chk($sformatf("row%0d_state", i), int'(state_o), vecs[i].st);
      chk($sformatf("row%0d_led1", i), int'(led1), vecs[i].l1);
      chk($sformatf("row%0d_led2", i), int'(led2), vecs[i].l2);
      $display("row %0d: en=%0d ir=%0d tin=%0d duty=%0d state=%0d led1=%0d led2=%0d",
               i, en, ir, tin, duty, state_o, led1, led2);
    end

    // asynchronous reset in the middle of a ramp
    en = 1'b1; ir = 1'b0; tin = 1'b0;
    sb.push_back(8'd50);
    repeat (5) @(negedge clk);
    chk("mid_ramp_duty", int'(duty), 50);
    chk("mid_ramp_state", int'(state_o), 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_duty", int'(duty), 0);
    chk("async_rst_upd", int'(duty_upd), 0);
    chk("async_rst_led1", int'(led1), 0);
    chk("async_rst_led2", int'(led2), 0);
    chk("async_rst_state", int'(state_o), 0);
    $display("async reset: duty=%0d state=%0d led1=%0d", duty, state_o, led1);
    @(negedge clk);
    rst_n = 1'b1; en = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_state", int'(state_o), 0);
    chk("post_rst_duty", int'(duty), 0);

    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
